// File: rtl/hack_pkg.sv
// Shared Hack CPU types and address helpers.
// Used by the program counter and the fetch unit.
package hack_pkg;

    localparam int HACK_ADDR_W = 15;
    localparam int HACK_WORD_W = 16;

    typedef logic [HACK_ADDR_W-1:0] hack_addr_t;
    typedef logic [HACK_WORD_W-1:0] hack_word_t;

    // ROM addresses wrap from the top word back to zero
    function automatic hack_addr_t hack_addr_inc(input hack_addr_t a);
        return a + hack_addr_t'(1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO between instruction ROM and decode.
// Flush empties it and wins over a same-cycle push.
module fetch_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    input  logic              flush,
    output logic [DATA_W-1:0] rdata,
    output logic              empty,
    output logic [CW-1:0]     count
);
    localparam int PW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    assign rdata = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Upstream credit accounting must never overrun the buffer
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && !flush && count_q == CW'(DEPTH)));

endmodule

// File: rtl/hack_fetch.sv
// Hack CPU instruction fetch: ROM request issue, prefetch buffering,
// and redirect on jump with discard of in-flight responses.
module hack_fetch
    import hack_pkg::*;
#(
    parameter int ADDR_W = HACK_ADDR_W,
    parameter int DATA_W = HACK_WORD_W,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              rom_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_gnt,
    input  logic              rom_rvalid,
    input  logic [DATA_W-1:0] rom_rdata,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_addr
);
    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] head_pc_q, head_pc_d;
    logic [CW-1:0]     outstanding_q, outstanding_d;
    logic [CW-1:0]     discard_q, discard_d;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic              credit_ok;
    logic              issue;
    logic              pop;
    logic              drop;
    logic              push;

    fetch_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .CW     (CW)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wdata   (rom_rdata),
        .pop     (pop),
        .flush   (jump),
        .rdata   (instr),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign rom_addr    = fetch_pc_q;
    assign instr_pc    = head_pc_q;
    assign instr_valid = !fifo_empty;

    always_comb begin
        // Every request reserves a FIFO slot until its word is popped
        credit_ok = ({1'b0, fifo_count} + {1'b0, outstanding_q}) < CREDITS;
        rom_req   = reset_n && !jump && credit_ok;
        issue     = rom_req && rom_gnt;
        pop       = instr_valid && instr_ready;
        drop      = rom_rvalid && (discard_q != '0);
        push      = rom_rvalid && !drop && !jump;

        outstanding_d = outstanding_q + CW'(issue) - CW'(rom_rvalid);
        fetch_pc_d    = issue ? fetch_pc_q + 1'b1 : fetch_pc_q;
        head_pc_d     = pop ? head_pc_q + 1'b1 : head_pc_q;
        discard_d     = drop ? discard_q - 1'b1 : discard_q;

        if (jump) begin
            fetch_pc_d = jump_addr;
            head_pc_d  = jump_addr;
            discard_d  = outstanding_q + CW'(issue) - CW'(rom_rvalid);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q    <= '0;
            head_pc_q     <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            head_pc_q     <= head_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

endmodule

// File: tb/tb_hack_fetch.sv
// Bench for hack_fetch: in-order ROM model with programmable latency,
// stream model of expected fetch/decode addresses, directed + random steps.
module tb_hack_fetch;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rom_req;
    logic [14:0] rom_addr;
    logic        rom_gnt = 1'b0;
    logic        rom_rvalid = 1'b0;
    logic [15:0] rom_rdata = '0;
    logic [15:0] instr;
    logic [14:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        jump = 1'b0;
    logic [14:0] jump_addr = '0;

    always #5 clk = ~clk;

    hack_fetch #(
        .ADDR_W (15),
        .DATA_W (16),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rom_req     (rom_req),
        .rom_addr    (rom_addr),
        .rom_gnt     (rom_gnt),
        .rom_rvalid  (rom_rvalid),
        .rom_rdata   (rom_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .jump        (jump),
        .jump_addr   (jump_addr)
    );

    typedef struct {
        int          due;
        logic [14:0] a;
    } rsp_t;

    rsp_t        pending[$];
    int          cyc = 0;
    int          lat = 1;
    int          errors = 0;
    int          checks = 0;
    logic        rst_next = 1'b0;
    logic [14:0] exp_pc = '0;
    logic [14:0] exp_fetch = '0;

    function automatic logic [15:0] mem(input logic [14:0] a);
        return {1'b0, a} ^ 16'h5A5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pending.delete();
        exp_pc    = '0;
        exp_fetch = '0;
    endtask

    // One clock cycle: drive inputs after the edge, check at the falling edge
    task automatic tick(input logic rdy, input logic g,
                        input logic jmp = 1'b0, input logic [14:0] ja = '0);
        rsp_t r;
        @(posedge clk);
        #1;
        cyc++;
        reset_n     = rst_next;
        instr_ready = rdy;
        rom_gnt     = g;
        jump        = jmp;
        jump_addr   = ja;
        if (pending.size() > 0 && pending[0].due <= cyc) begin
            r          = pending.pop_front();
            rom_rvalid = 1'b1;
            rom_rdata  = mem(r.a);
        end else begin
            rom_rvalid = 1'b0;
            rom_rdata  = 16'($urandom);
        end
        @(negedge clk);
        if (instr_valid) begin
            chk("instr_data", 32'(instr), 32'(mem(instr_pc)));
            chk("instr_pc_seq", 32'(instr_pc), 32'(exp_pc));
        end
        if (rom_req) chk("rom_addr_seq", 32'(rom_addr), 32'(exp_fetch));
        if (jump) chk("no_req_on_jump", 32'(rom_req), 32'(0));
        if (reset_n) chk("credit", 32'(pending.size() <= DEPTH), 32'(1));
        if (rom_req && rom_gnt) begin
            pending.push_back('{cyc + lat, rom_addr});
            exp_fetch = exp_fetch + 15'd1;
        end
        if (instr_valid && instr_ready) exp_pc = exp_pc + 15'd1;
        if (jump) begin
            exp_pc    = jump_addr;
            exp_fetch = jump_addr;
        end
    endtask

    task automatic wait_valid(input string tag, input int maxc, output int n);
        n = 0;
        do begin
            tick(1'b1, 1'b1);
            n++;
        end while (!instr_valid && n < maxc);
        chk(tag, 32'(instr_valid), 32'(1));
    endtask

    task automatic async_reset(input string tag);
        reset_n  = 1'b0;
        rst_next = 1'b0;
        model_reset();
        #1;
        chk({tag, "_req"}, 32'(rom_req), 32'(0));
        chk({tag, "_valid"}, 32'(instr_valid), 32'(0));
        chk({tag, "_instr"}, 32'(instr), 32'(0));
        chk({tag, "_pc"}, 32'(instr_pc), 32'(0));
    endtask

    initial begin
        int n;
        int reqs;

        // Reset and streaming at one word per cycle
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        chk("rst_req", 32'(rom_req), 32'(0));
        chk("rst_valid", 32'(instr_valid), 32'(0));
        chk("rst_instr", 32'(instr), 32'(0));
        chk("rst_pc", 32'(instr_pc), 32'(0));
        rst_next = 1'b1;
        tick(1'b1, 1'b1);
        chk("t1_req0", 32'(rom_req), 32'(1));
        chk("t1_addr0", 32'(rom_addr), 32'(0));
        chk("t1_v0", 32'(instr_valid), 32'(0));
        tick(1'b1, 1'b1);
        chk("t1_v1", 32'(instr_valid), 32'(0));
        tick(1'b1, 1'b1);
        chk("t1_v2", 32'(instr_valid), 32'(1));
        chk("t1_pc2", 32'(instr_pc), 32'(0));
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 1'b1);
            chk("t1_stream", 32'(instr_valid), 32'(1));
        end

        // Back-pressure: credits cap requests at DEPTH
        async_reset("t2_rst");
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        rst_next = 1'b1;
        reqs = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b1);
            reqs += int'(rom_req);
        end
        chk("t2_reqs", 32'(reqs), 32'(DEPTH));
        chk("t2_req_off", 32'(rom_req), 32'(0));
        chk("t2_hold_v", 32'(instr_valid), 32'(1));
        chk("t2_hold_pc", 32'(instr_pc), 32'(0));
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b1);
            chk("t2_drain_v", 32'(instr_valid), 32'(1));
            chk("t2_drain_pc", 32'(instr_pc), 32'(i));
        end

        // Jump with two responses in flight, ROM latency 3
        lat = 3;
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        chk("t3_inflight", 32'(pending.size()), 32'(2));
        tick(1'b1, 1'b1, 1'b1, 15'd12345);
        wait_valid("t3_valid0", 20, n);
        chk("t3_pc0", 32'(instr_pc), 32'(12345));
        wait_valid("t3_valid1", 20, n);
        chk("t3_pc1", 32'(instr_pc), 32'(12346));

        // Reset with three requests outstanding
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        chk("t5_inflight", 32'(pending.size()), 32'(3));
        async_reset("t5_rst");
        lat = 1;
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        rst_next = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick(1'b1, 1'b1);
            if (i == 1) chk("t5_v1", 32'(instr_valid), 32'(0));
            if (i == 2) chk("t5_first_pc", 32'(instr_pc), 32'(0));
        end

        // Jump coinciding with the pop of pc 7, target at top of ROM
        tick(1'b1, 1'b1, 1'b1, 15'h7FFF);
        chk("t4_pop_v", 32'(instr_valid), 32'(1));
        chk("t4_pop_pc", 32'(instr_pc), 32'(7));
        tick(1'b1, 1'b1);
        chk("t4_gap1", 32'(instr_valid), 32'(0));
        tick(1'b1, 1'b1);
        chk("t4_gap2", 32'(instr_valid), 32'(0));
        tick(1'b1, 1'b1);
        chk("t4_tgt_v", 32'(instr_valid), 32'(1));
        chk("t4_tgt_pc", 32'(instr_pc), 32'(15'h7FFF));
        tick(1'b1, 1'b1);
        chk("t4_wrap_v", 32'(instr_valid), 32'(1));
        chk("t4_wrap_pc", 32'(instr_pc), 32'(0));

        // Random grant, ready and jumps
        lat = 2;
        for (int i = 0; i < 10000; i++) begin
            logic        rr;
            logic        gg;
            logic        jj;
            logic [14:0] aa;
            rr = ($urandom_range(3) != 0);
            gg = $urandom_range(1) == 1;
            jj = ($urandom_range(31) == 0);
            aa = ($urandom_range(3) == 0) ? 15'h7FFE : 15'($urandom);
            tick(rr, gg, jj, aa);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
